// File: rtl/keypad_encoder_if.sv
// rtl/keypad_encoder_if.sv - keypad matrix lines and encoded-key outputs
interface keypad_encoder_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [6:0] key_data_out;
  logic       key_data_ready;

  modport master (input row, output col, output key_data_out, output key_data_ready);
  modport slave  (output row, input col, input key_data_out, input key_data_ready);
endinterface

// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - 4x4 active-low keypad scanner, debouncer and ASCII encoder
// Auto-repeat while a key is held is enabled by defining KEYPAD_TYPEMATIC_EN.
module keypad_encoder #(
  parameter int SCAN_DIV        = 64,
  parameter int DEBOUNCE_FRAMES = 4,
`ifdef KEYPAD_TYPEMATIC_EN
  parameter int REPEAT_DELAY    = 250,
  parameter int REPEAT_RATE     = 60,
`endif
  parameter int READY_HOLD      = 8
) (
  input  logic             clk,
  input  logic             rst,
  keypad_encoder_if.master kp
);
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int HOLD_W = $clog2(READY_HOLD + 1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_REPORT, S_WAIT_RELEASE} state_t;

  logic [DIV_W-1:0]  r_div;
  logic [1:0]        r_idx;
  logic [3:0]        r_row_s1;
  logic [3:0]        r_row_s2;
  logic [11:0]       r_frame;
  logic              w_col_last;
  logic              w_frame_end;
  logic [15:0]       w_frame;
  logic [4:0]        w_nkeys;
  logic [6:0]        w_code;
  logic              w_none;
  logic              w_one;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [6:0]        r_cand;
  logic [6:0]        w_cand_nxt;
  logic              w_report;

  logic [6:0]        r_data;
  logic              r_ready;
  logic [HOLD_W-1:0] r_hold;

  function automatic logic [6:0] key_ascii(input logic [3:0] idx);
    case (idx)
      4'd0:    key_ascii = 7'h31;
      4'd1:    key_ascii = 7'h32;
      4'd2:    key_ascii = 7'h33;
      4'd3:    key_ascii = 7'h41;
      4'd4:    key_ascii = 7'h34;
      4'd5:    key_ascii = 7'h35;
      4'd6:    key_ascii = 7'h36;
      4'd7:    key_ascii = 7'h42;
      4'd8:    key_ascii = 7'h37;
      4'd9:    key_ascii = 7'h38;
      4'd10:   key_ascii = 7'h39;
      4'd11:   key_ascii = 7'h43;
      4'd12:   key_ascii = 7'h2A;
      4'd13:   key_ascii = 7'h30;
      4'd14:   key_ascii = 7'h23;
      default: key_ascii = 7'h44;
    endcase
  endfunction

  assign w_col_last  = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_frame_end = w_col_last && (r_idx == 2'd3);
  assign kp.col      = ~(4'b0001 << r_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= '0;
      r_idx    <= '0;
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
      r_frame  <= '0;
    end else begin
      r_row_s1 <= kp.row;
      r_row_s2 <= r_row_s1;
      if (w_col_last) begin
        r_div <= '0;
        r_idx <= r_idx + 2'd1;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 3; c++)
            if (r_idx == 2'(c)) r_frame[r*3+c] <= ~r_row_s2[r];
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // Column 3 is classified straight from the synchronizer on the frame-end cycle.
  always_comb begin
    w_frame = '0;
    w_nkeys = '0;
    w_code  = 7'h20;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) w_frame[r*4+c] = r_frame[r*3+c];
      w_frame[r*4+3] = ~r_row_s2[r];
    end
    for (int i = 0; i < 16; i++) begin
      if (w_frame[i]) begin
        w_nkeys = w_nkeys + 5'd1;
        w_code  = key_ascii(4'(i));
      end
    end
  end

  assign w_none    = (w_nkeys == 5'd0);
  assign w_one     = (w_nkeys == 5'd1);
  assign w_cnt_inc = r_cnt + 1'b1;

`ifdef KEYPAD_TYPEMATIC_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] r_rep;
  logic [REP_W-1:0] w_rep_nxt;
  logic [REP_W-1:0] w_rep_inc;
  logic [REP_W-1:0] w_rep_target;
  logic             r_rep_started;
  logic             w_rep_started_nxt;

  assign w_rep_inc    = r_rep + 1'b1;
  assign w_rep_target = r_rep_started ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_SCAN;
      r_cnt   <= '0;
      r_cand  <= 7'h20;
`ifdef KEYPAD_TYPEMATIC_EN
      r_rep         <= '0;
      r_rep_started <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
`ifdef KEYPAD_TYPEMATIC_EN
      r_rep         <= w_rep_nxt;
      r_rep_started <= w_rep_started_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_report    = 1'b0;
`ifdef KEYPAD_TYPEMATIC_EN
    w_rep_nxt         = r_rep;
    w_rep_started_nxt = r_rep_started;
`endif
    case (r_state)
      S_SCAN: begin
        if (w_frame_end && w_one) begin
          w_state_nxt = S_DEBOUNCE;
          w_cand_nxt  = w_code;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_DEBOUNCE: begin
        if (w_frame_end) begin
          if (w_one && (w_code == r_cand)) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
              w_state_nxt = S_REPORT;
`ifdef KEYPAD_TYPEMATIC_EN
              w_rep_nxt         = '0;
              w_rep_started_nxt = 1'b0;
`endif
            end
          end else if (w_one) begin
            w_cand_nxt = w_code;
            w_cnt_nxt  = CNT_W'(1);
          end else begin
            w_state_nxt = S_SCAN;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_REPORT: begin
        w_report    = 1'b1;
        w_state_nxt = S_WAIT_RELEASE;
        w_cnt_nxt   = '0;
      end
      default: begin
        if (w_frame_end) begin
          if (w_none) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
              w_state_nxt = S_SCAN;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = '0;
          end
`ifdef KEYPAD_TYPEMATIC_EN
          if (w_one && (w_code == r_cand)) begin
            w_rep_nxt = w_rep_inc;
            if (w_rep_inc == w_rep_target) begin
              w_state_nxt       = S_REPORT;
              w_rep_nxt         = '0;
              w_rep_started_nxt = 1'b1;
            end
          end else begin
            w_rep_nxt         = '0;
            w_rep_started_nxt = 1'b0;
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= 7'h20;
      r_ready <= 1'b0;
      r_hold  <= '0;
    end else if (w_report) begin
      r_data  <= r_cand;
      r_ready <= 1'b1;
      r_hold  <= HOLD_W'(READY_HOLD - 1);
    end else if (r_hold != '0) begin
      r_hold <= r_hold - 1'b1;
    end else begin
      r_ready <= 1'b0;
    end
  end

  assign kp.key_data_out   = r_data;
  assign kp.key_data_ready = r_ready;
endmodule
